booth_arbiter: RTL and testbench
================================

Name: booth_arbiter

Overview:
- Round-robin scheduler that shares one 6x6 signed booth multiplier (ports clk, n_rst, M, Q, start, result) between NREQ requesters.
- Latches the winning requester's operands and pulses the multiplier start.
- Waits a fixed LATENCY, captures the 12-bit product and returns it with a one-cycle valid pulse to the owning requester.
- Sits between requester blocks and the single booth instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 8, cycles from the clock edge that samples mul_start high to the edge at which mul_result is captured (1..255).

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous active-low reset
- req  input  NREQ  per-requester request level
- m_in  input  NREQ*6  requester operands M, requester i at bits [6i+5:6i], two's complement
- q_in  input  NREQ*6  requester operands Q, same packing
- gnt  output  NREQ  one-hot; high from ISSUE through DONE for the served requester
- rsp_valid  output  NREQ  one-hot one-cycle pulse, product available
- rsp_data  output  12  captured product, shared by all requesters
- busy  output  1  high in any state except IDLE
- mul_M  output  6  registered operand M to the multiplier
- mul_Q  output  6  registered operand Q to the multiplier
- mul_start  output  1  one-cycle start pulse to the multiplier
- mul_result  input  12  multiplier product

Behaviour:
- Reset (n_rst low at a rising edge):
  - state=IDLE; gnt, rsp_valid, mul_start and busy = 0; mul_M, mul_Q and rsp_data = 0; cnt=0.
  - ptr=NREQ-1, so requester 0 has top priority first.
  - Reset mid-operation abandons the operation; no rsp_valid is produced for it.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req is nonzero, pick the first set bit scanning ptr+1, ptr+2, ... modulo NREQ.
  - Latch that requester's m_in/q_in into mul_M/mul_Q, set gid, go to ISSUE.
  - If req is 0, stay in IDLE.
- ISSUE (1 cycle):
  - mul_start=1, gnt[gid]=1, cnt cleared, go to WAIT.
- WAIT:
  - cnt increments each cycle.
  - At the edge where cnt==LATENCY-1, capture mul_result into rsp_data and go to DONE.
  - mul_M/mul_Q are held constant from ISSUE until DONE exits.
- DONE (1 cycle):
  - rsp_valid[gid]=1, gnt[gid]=1; ptr<=gid; go to IDLE.
- Timing:
  - rsp_valid rises LATENCY+2 cycles after the IDLE cycle in which the request was sampled.
  - Back-to-back throughput is one product per LATENCY+3 cycles.
- Handshake:
  - A requester holds req and its operands until gnt rises.
  - Operands may change once gnt is seen, since they are already latched.
  - A requester must deassert req no later than the cycle after its rsp_valid pulse, otherwise it is served again when it is the only requester.
- req dropped after the grant: the operation still completes and rsp_valid still pulses.
- Simultaneous requests: only the round-robin winner is served; the others wait, and no request is lost while req is held.
- Fairness: a just-served requester has lowest priority on the next arbitration, so no continuous requester can starve another.
- Arithmetic:
  - The arbiter does no arithmetic; rsp_data is mul_result verbatim (12-bit two's complement product).
  - rsp_data holds its last value until the next capture.

Test Plan:
- Single request: req[0], M=6'b110100 (-12), Q=6'b011110 (30) -> mul_start pulses once with mul_M=-12, mul_Q=30; rsp_valid[0] pulses 10 cycles after the sampling IDLE cycle; rsp_data=12'hE98 (-360).
- Sequential requests on different ports: req[1] with -7*3 (6'b111001, 6'b000011) -> rsp_data=12'hFEB on rsp_valid[1]; then req[3] with 8*4 -> 12'h020 on rsp_valid[3]; gnt stays one-hot throughout.
- Contention: all four req rise together after reset with distinct operands -> serviced in order 0,1,2,3; each rsp_valid is one cycle long; responses are 11 cycles apart.
- Fairness: req[0] and req[2] held high continuously (re-armed after each response) -> grants alternate 0,2,0,2; neither requester is served twice in a row.
- Extreme operands: M=Q=6'b100000 (-32*-32) -> rsp_data=12'h400; M=6'b100000, Q=6'b011111 -> 12'hC20 (-992).
- Reset mid-WAIT: assert n_rst low at cnt=3 -> next cycle busy=0, gnt=0, mul_start=0; no rsp_valid; after release, req[0] held is served normally with top priority.

Source files
------------

// File: rtl/booth_arbiter.sv
// Round-robin front end that time-shares one 6x6 signed booth multiplier between
// NREQ requesters: latch operands, pulse start, wait LATENCY, return the product.
module booth_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*6-1:0]   m_in,
  input  logic [NREQ*6-1:0]   q_in,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [11:0]         rsp_data,
  output logic                busy,
  output logic [5:0]          mul_M,
  output logic [5:0]          mul_Q,
  output logic                mul_start,
  input  logic [11:0]         mul_result
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gid_q, gid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      mul_m_q, mul_m_d;
  logic [5:0]      mul_q_q, mul_q_d;
  logic [11:0]     rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic            mul_start_q, mul_start_d;
  logic            busy_q, busy_d;

  logic [5:0]      m_arr [NREQ];
  logic [5:0]      q_arr [NREQ];
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  int              scan_pos;

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Unpack the flat operand buses into per-requester slots.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      m_arr[i] = m_in[6*i +: 6];
      q_arr[i] = q_in[6*i +: 6];
    end
  end

  // Round-robin pick: first requester after the last-served one, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_pos = int'(ptr_q) + k;
      if (scan_pos >= NREQ) begin
        scan_pos = scan_pos - NREQ;
      end else begin
        scan_pos = scan_pos;
      end
      if (!pick_found && req[PW'(scan_pos)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(scan_pos);
      end else begin
        pick_found = pick_found;
      end
    end
  end

  // Next-state and next-output logic; outputs are registered one cycle ahead of their state.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    cnt_d       = cnt_q;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    rsp_data_d  = rsp_data_q;
    gnt_d       = gnt_q;
    rsp_valid_d = '0;
    mul_start_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_ISSUE;
          gid_d       = pick_idx;
          mul_m_d     = m_arr[pick_idx];
          mul_q_d     = q_arr[pick_idx];
          gnt_d       = onehot(pick_idx);
          mul_start_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CW'(LATENCY - 1)) begin
          rsp_data_d  = mul_result;
          rsp_valid_d = onehot(gid_q);
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        ptr_d   = gid_q;
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(NREQ - 1);
      gid_q       <= '0;
      cnt_q       <= '0;
      mul_m_q     <= 6'd0;
      mul_q_q     <= 6'd0;
      rsp_data_q  <= 12'd0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      mul_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      cnt_q       <= cnt_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      rsp_data_q  <= rsp_data_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      mul_start_q <= mul_start_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
  assign mul_M     = mul_m_q;
  assign mul_Q     = mul_q_q;
  assign mul_start = mul_start_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: directed scenarios plus random traffic, checked every
// cycle against a timeline model of the arbitration and a mock booth multiplier.
module tb_booth_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*6-1:0] m_in, q_in;
  logic [NREQ-1:0]   gnt, rsp_valid;
  logic [11:0]       rsp_data, mul_result;
  logic              busy, mul_start;
  logic [5:0]        mul_M, mul_Q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .m_in(m_in), .q_in(q_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .mul_M(mul_M), .mul_Q(mul_Q), .mul_start(mul_start), .mul_result(mul_result)
  );

  function automatic logic [11:0] prod12(input logic [5:0] a, input logic [5:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[11:0];
  endfunction

  // Mock multiplier: the true product appears only in the cycle just before capture is due.
  int         mul_cnt  = 0;
  logic [11:0] mul_prod = 12'd0;
  always @(posedge clk) begin
    if (mul_start === 1'b1) begin
      mul_cnt  <= 1;
      mul_prod <= prod12(mul_M, mul_Q);
    end else if (mul_cnt != 0 && mul_cnt < 1000) begin
      mul_cnt <= mul_cnt + 1;
    end
  end
  assign mul_result = (mul_cnt == LAT) ? mul_prod : ~mul_prod;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Timeline model: one operation occupies LAT+3 edges counted from its grant edge.
  bit         m_busy = 1'b0;
  int         m_ptr  = NREQ - 1;
  int         m_gid  = 0;
  int         m_e    = 0;
  logic [5:0] e_m = 6'd0, e_q = 6'd0;
  logic [11:0] e_data = 12'd0, m_prod = 12'd0;

  task automatic model_edge();
    int j;
    if (!n_rst) begin
      m_busy = 1'b0; m_ptr = NREQ - 1; m_e = 0;
      e_m = 6'd0; e_q = 6'd0; e_data = 12'd0;
    end else if (!m_busy) begin
      if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (req[j]) begin
            m_gid = j;
            break;
          end
        end
        m_busy = 1'b1; m_e = 1;
        e_m = m_in[m_gid*6 +: 6];
        e_q = q_in[m_gid*6 +: 6];
        m_prod = prod12(e_m, e_q);
      end
    end else begin
      m_e++;
      if (m_e == LAT + 2) e_data = m_prod;
      if (m_e == LAT + 3) begin
        m_busy = 1'b0;
        m_ptr  = m_gid;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] eg, ev;
    eg = '0; ev = '0;
    if (m_busy) eg[m_gid] = 1'b1;
    if (m_busy && m_e == LAT + 2) ev[m_gid] = 1'b1;
    check_eq("gnt", gnt, eg);
    check_eq("rsp_valid", rsp_valid, ev);
    check_eq("rsp_data", rsp_data, e_data);
    check_eq("busy", busy, m_busy);
    check_eq("mul_start", mul_start, (m_busy && m_e == 1));
    check_eq("mul_M", mul_M, e_m);
    check_eq("mul_Q", mul_Q, e_q);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic serve(input int id, input logic [5:0] mm, input logic [5:0] qq,
                       input logic [11:0] exp);
    int n;
    bit seen;
    n = 0; seen = 1'b0;
    req[id] = 1'b1;
    m_in[id*6 +: 6] = mm;
    q_in[id*6 +: 6] = qq;
    while (!seen && n < 40) begin
      cycle();
      n++;
      if (gnt[id]) begin
        req[id] = 1'b0;
        m_in[id*6 +: 6] = 6'($urandom);
        q_in[id*6 +: 6] = 6'($urandom);
      end
      if (rsp_valid[id]) begin
        seen = 1'b1;
        check_eq("serve_latency", n, LAT + 2);
        check_eq("serve_data", rsp_data, exp);
      end
    end
    check_eq("serve_seen", seen, 1'b1);
    cycle();
  endtask

  initial begin
    int order[$];
    int times[$];
    int t, first, nrsp;
    logic [11:0] cont_exp [NREQ];
    logic [5:0]  tm, tq;
    int fair_exp [4] = '{0, 2, 0, 2};

    n_rst = 1'b0; req = '0; m_in = '0; q_in = '0;
    repeat (3) cycle();
    n_rst = 1'b1;
    cycle();

    serve(0, 6'b110100, 6'b011110, 12'hE98);
    serve(1, 6'b111001, 6'b000011, 12'hFEB);
    serve(3, 6'b001000, 6'b000100, 12'h020);
    serve(0, 6'b100000, 6'b100000, 12'h400);
    serve(0, 6'b100000, 6'b011111, 12'hC20);

    // Contention: all four request together right after a reset.
    n_rst = 1'b0; cycle(); n_rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      tm = 6'(5 * i - 9);
      tq = 6'(7 - 3 * i);
      m_in[i*6 +: 6] = tm;
      q_in[i*6 +: 6] = tq;
      cont_exp[i] = prod12(tm, tq);
    end
    req = '1;
    t = 0;
    while (order.size() < NREQ && t < 100) begin
      cycle();
      t++;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        if (rsp_valid[i]) begin
          order.push_back(i);
          times.push_back(t);
          check_eq("cont_data", rsp_data, cont_exp[i]);
        end
      end
    end
    check_eq("cont_count", order.size(), NREQ);
    for (int k = 0; k < order.size(); k++) begin
      check_eq("cont_order", order[k], k);
      if (k > 0) check_eq("cont_gap", times[k] - times[k-1], LAT + 3);
    end
    cycle();

    // Fairness: requesters 0 and 2 hold req continuously.
    order.delete();
    m_in[5:0] = 6'd3;   q_in[5:0] = 6'd9;
    m_in[17:12] = 6'd2; q_in[17:12] = 6'd31;
    req = 4'b0101;
    t = 0;
    while (order.size() < 4 && t < 100) begin
      cycle();
      t++;
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) order.push_back(i);
      end
      if (order.size() == 4) req = '0;
    end
    check_eq("fair_count", order.size(), 4);
    for (int k = 0; k < order.size() && k < 4; k++) check_eq("fair_order", order[k], fair_exp[k]);
    cycle();

    // Reset in the middle of WAIT, then requester 0 must win first.
    req = 4'b0001; m_in[5:0] = 6'd13; q_in[5:0] = 6'd5;
    repeat (5) cycle();
    check_eq("rst_busy_pre", busy, 1'b1);
    n_rst = 1'b0;
    req[1] = 1'b1; m_in[11:6] = 6'd21; q_in[11:6] = 6'd2;
    cycle();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_gnt", gnt, 4'b0000);
    check_eq("rst_start", mul_start, 1'b0);
    n_rst = 1'b1;
    first = -1; nrsp = 0; t = 0;
    while (nrsp < 2 && t < 60) begin
      cycle();
      t++;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && first < 0) first = i;
        if (gnt[i]) req[i] = 1'b0;
      end
      if (rsp_valid != '0) nrsp++;
    end
    check_eq("rst_first", first, 0);
    check_eq("rst_nrsp", nrsp, 2);

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      n_rst = ($urandom_range(0, 149) != 0);
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          req[i] = 1'b0;
        end else if (req[i] && gnt[i]) begin
          m_in[i*6 +: 6] = 6'($urandom);
          q_in[i*6 +: 6] = 6'($urandom);
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          m_in[i*6 +: 6] = 6'($urandom);
          q_in[i*6 +: 6] = 6'($urandom);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
